// File: rtl/letter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | letter_pkg                                                       |
// | Shared widths, colours and letter codes for the text plotter.    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package letter_pkg;

    localparam int LETTER_W = 4;
    localparam int GLYPH_W  = 8;
    localparam int GLYPH_H  = 16;
    localparam int COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
    localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

    localparam logic [LETTER_W-1:0] L_A = 4'd0;
    localparam logic [LETTER_W-1:0] L_B = 4'd1;
    localparam logic [LETTER_W-1:0] L_C = 4'd2;
    localparam logic [LETTER_W-1:0] L_D = 4'd3;
    localparam logic [LETTER_W-1:0] L_E = 4'd4;
    localparam logic [LETTER_W-1:0] L_F = 4'd5;
    localparam logic [LETTER_W-1:0] L_G = 4'd6;
    localparam logic [LETTER_W-1:0] L_H = 4'd7;
    localparam logic [LETTER_W-1:0] L_I = 4'd8;
    localparam logic [LETTER_W-1:0] L_J = 4'd9;
    localparam logic [LETTER_W-1:0] L_K = 4'd10;
    localparam logic [LETTER_W-1:0] L_L = 4'd11;
    localparam logic [LETTER_W-1:0] L_M = 4'd12;
    localparam logic [LETTER_W-1:0] L_N = 4'd13;
    localparam logic [LETTER_W-1:0] L_O = 4'd14;
    localparam logic [LETTER_W-1:0] L_P = 4'd15;

endpackage
`default_nettype wire

// File: rtl/letterROMSV.sv
`default_nettype none
// +------------------------------------------------------------------+
// | letterROMSV                                                      |
// | 8x16 glyph ROM: 5x7 letters doubled vertically, 1px top margin.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module letterROMSV
    import letter_pkg::*;
(
    input  logic [LETTER_W-1:0] i_code,
    input  logic [2:0]          i_gx,
    input  logic [3:0]          i_gy,
    output logic                o_lit
);

    logic [34:0] w_bits;
    logic [2:0]  w_r;
    logic [4:0]  w_row5;
    logic [7:0]  w_row;

    // Seven 5-bit rows per letter, top row in the MSBs, leftmost pixel in bit 4
    always_comb begin
        case (i_code)
            L_A: w_bits = {5'b01110, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b10001};
            L_B: w_bits = {5'b11110, 5'b10001, 5'b10001, 5'b11110, 5'b10001, 5'b10001, 5'b11110};
            L_C: w_bits = {5'b01110, 5'b10001, 5'b10000, 5'b10000, 5'b10000, 5'b10001, 5'b01110};
            L_D: w_bits = {5'b11110, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b11110};
            L_E: w_bits = {5'b11111, 5'b10000, 5'b10000, 5'b11110, 5'b10000, 5'b10000, 5'b11111};
            L_F: w_bits = {5'b11111, 5'b10000, 5'b10000, 5'b11110, 5'b10000, 5'b10000, 5'b10000};
            L_G: w_bits = {5'b01110, 5'b10001, 5'b10000, 5'b10111, 5'b10001, 5'b10001, 5'b01111};
            L_H: w_bits = {5'b10001, 5'b10001, 5'b10001, 5'b11111, 5'b10001, 5'b10001, 5'b10001};
            L_I: w_bits = {5'b01110, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110};
            L_J: w_bits = {5'b00111, 5'b00010, 5'b00010, 5'b00010, 5'b00010, 5'b10010, 5'b01100};
            L_K: w_bits = {5'b10001, 5'b10010, 5'b10100, 5'b11000, 5'b10100, 5'b10010, 5'b10001};
            L_L: w_bits = {5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b11111};
            L_M: w_bits = {5'b10001, 5'b11011, 5'b10101, 5'b10101, 5'b10001, 5'b10001, 5'b10001};
            L_N: w_bits = {5'b10001, 5'b10001, 5'b11001, 5'b10101, 5'b10011, 5'b10001, 5'b10001};
            L_O: w_bits = {5'b01110, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b10001, 5'b01110};
            L_P: w_bits = {5'b11110, 5'b10001, 5'b10001, 5'b11110, 5'b10000, 5'b10000, 5'b10000};
            default: w_bits = '0;
        endcase
    end

    assign w_r = 3'((i_gy - 4'd1) >> 1);

    always_comb begin
        case (w_r)
            3'd0:    w_row5 = w_bits[34:30];
            3'd1:    w_row5 = w_bits[29:25];
            3'd2:    w_row5 = w_bits[24:20];
            3'd3:    w_row5 = w_bits[19:15];
            3'd4:    w_row5 = w_bits[14:10];
            3'd5:    w_row5 = w_bits[9:5];
            3'd6:    w_row5 = w_bits[4:0];
            default: w_row5 = '0;
        endcase
    end

    // Glyph occupies columns 1..5; row 0 and row 15 are blank spacing
    assign w_row = {1'b0, w_row5, 2'b00};
    assign o_lit = (i_gy != 4'd0) && (i_gy != 4'(GLYPH_H - 1)) && w_row[3'd7 - i_gx];

endmodule
`default_nettype wire

// File: rtl/letter_plotter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | letter_plotter                                                   |
// | Full-frame pixel sweep rendering a 2x16 letter buffer + cursor.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module letter_plotter
    import letter_pkg::*;
#(
    parameter int COLS   = 16,
    parameter int ROW0_Y = 0,
    parameter int ROW1_Y = 20,
    parameter int CUR_X  = 80,
    parameter int CUR_Y  = 80,
    parameter int H_RES  = 160,
    parameter int V_RES  = 120
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                run,
    input  logic [COLOUR_W-1:0] fg_colour,
    input  logic                wr_en,
    input  logic                wr_row,
    input  logic [3:0]          wr_col,
    input  logic [LETTER_W-1:0] wr_code,
    input  logic                wr_vis,
    input  logic [LETTER_W-1:0] cur_code,
    input  logic                cur_vis,
    output logic [7:0]          x,
    output logic [6:0]          y,
    output logic [COLOUR_W-1:0] colour,
    output logic                plot,
    output logic                frame_done
);

    localparam int         c_CELLS  = 2 * COLS;
    localparam logic [7:0] c_X_LAST = 8'(H_RES - 1);
    localparam logic [6:0] c_Y_LAST = 7'(V_RES - 1);

    logic [7:0]          r_sx;
    logic [6:0]          r_sy;
    logic [LETTER_W:0]   r_buf [c_CELLS];

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_sx <= '0;
            r_sy <= '0;
        end else if (run) begin
            if (r_sx == c_X_LAST) begin
                r_sx <= '0;
                r_sy <= (r_sy == c_Y_LAST) ? 7'd0 : r_sy + 7'd1;
            end else begin
                r_sx <= r_sx + 8'd1;
            end
        end
    end

    // Each entry is {vis, code}
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < c_CELLS; i++) r_buf[i] <= '0;
        end else if (wr_en) begin
            r_buf[{wr_row, wr_col}] <= {wr_vis, wr_code};
        end
    end

    // Offsets wrap to large values above the region, so one compare bounds both sides
    logic [6:0]          w_dy0, w_dy1, w_cdy;
    logic [7:0]          w_cdx;
    logic                w_in_row0, w_in_row1, w_in_cols, w_in_cur;
    logic [LETTER_W:0]   w_cell;
    logic [LETTER_W-1:0] w_code;
    logic                w_vis;
    logic [2:0]          w_gx;
    logic [3:0]          w_gy;

    assign w_dy0     = r_sy - 7'(ROW0_Y);
    assign w_dy1     = r_sy - 7'(ROW1_Y);
    assign w_cdx     = r_sx - 8'(CUR_X);
    assign w_cdy     = r_sy - 7'(CUR_Y);
    assign w_in_row0 = w_dy0 < 7'(GLYPH_H);
    assign w_in_row1 = w_dy1 < 7'(GLYPH_H);
    assign w_in_cols = r_sx < 8'(GLYPH_W * COLS);
    assign w_in_cur  = (w_cdx < 8'(GLYPH_W)) && (w_cdy < 7'(GLYPH_H));
    assign w_cell    = r_buf[{~w_in_row0, r_sx[6:3]}];

    always_comb begin
        w_code = '0;
        w_vis  = 1'b0;
        w_gx   = r_sx[2:0];
        w_gy   = '0;
        if (w_in_cur) begin
            w_code = cur_code;
            w_vis  = cur_vis;
            w_gx   = w_cdx[2:0];
            w_gy   = w_cdy[3:0];
        end else if (w_in_cols && (w_in_row0 || w_in_row1)) begin
            w_code = w_cell[LETTER_W-1:0];
            w_vis  = w_cell[LETTER_W];
            w_gy   = w_in_row0 ? w_dy0[3:0] : w_dy1[3:0];
        end
    end

    logic [LETTER_W-1:0] r1_code;
    logic                r1_vis;
    logic [2:0]          r1_gx;
    logic [3:0]          r1_gy;
    logic [7:0]          r1_sx;
    logic [6:0]          r1_sy;
    logic [COLOUR_W-1:0] r1_fg;
    logic                r1_valid;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r1_code  <= '0;
            r1_vis   <= 1'b0;
            r1_gx    <= '0;
            r1_gy    <= '0;
            r1_sx    <= '0;
            r1_sy    <= '0;
            r1_fg    <= '0;
            r1_valid <= 1'b0;
        end else begin
            r1_code  <= w_code;
            r1_vis   <= w_vis;
            r1_gx    <= w_gx;
            r1_gy    <= w_gy;
            r1_sx    <= r_sx;
            r1_sy    <= r_sy;
            r1_fg    <= fg_colour;
            r1_valid <= run;
        end
    end

    logic w_lit;

    letterROMSV u_rom (
        .i_code (r1_code),
        .i_gx   (r1_gx),
        .i_gy   (r1_gy),
        .o_lit  (w_lit)
    );

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            x          <= '0;
            y          <= '0;
            colour     <= BLACK;
            plot       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            x          <= r1_sx;
            y          <= r1_sy;
            colour     <= (r1_vis && w_lit) ? r1_fg : BLACK;
            plot       <= r1_valid;
            frame_done <= r1_valid && (r1_sx == c_X_LAST) && (r1_sy == c_Y_LAST);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_letter_plotter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_letter_plotter                                                |
// | Randomised bench against a pixel-level reference of the screen.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_letter_plotter;

    logic       CLOCK_50 = 1'b0;
    logic       reset, run, wr_en, wr_row, wr_vis, cur_vis;
    logic [2:0] fg_colour;
    logic [3:0] wr_col, wr_code, cur_code;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, frame_done;

    always #10 CLOCK_50 = ~CLOCK_50;

    letter_plotter dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .run        (run),
        .fg_colour  (fg_colour),
        .wr_en      (wr_en),
        .wr_row     (wr_row),
        .wr_col     (wr_col),
        .wr_code    (wr_code),
        .wr_vis     (wr_vis),
        .cur_code   (cur_code),
        .cur_vis    (cur_vis),
        .x          (x),
        .y          (y),
        .colour     (colour),
        .plot       (plot),
        .frame_done (frame_done)
    );

    // Letters A..P as 5x7 pictures; each row is drawn twice on screen
    string font [16][7] = '{
        '{".###.", "#...#", "#...#", "#####", "#...#", "#...#", "#...#"},
        '{"####.", "#...#", "#...#", "####.", "#...#", "#...#", "####."},
        '{".###.", "#...#", "#....", "#....", "#....", "#...#", ".###."},
        '{"####.", "#...#", "#...#", "#...#", "#...#", "#...#", "####."},
        '{"#####", "#....", "#....", "####.", "#....", "#....", "#####"},
        '{"#####", "#....", "#....", "####.", "#....", "#....", "#...."},
        '{".###.", "#...#", "#....", "#.###", "#...#", "#...#", ".####"},
        '{"#...#", "#...#", "#...#", "#####", "#...#", "#...#", "#...#"},
        '{".###.", "..#..", "..#..", "..#..", "..#..", "..#..", ".###."},
        '{"..###", "...#.", "...#.", "...#.", "...#.", "#..#.", ".##.."},
        '{"#...#", "#..#.", "#.#..", "##...", "#.#..", "#..#.", "#...#"},
        '{"#....", "#....", "#....", "#....", "#....", "#....", "#####"},
        '{"#...#", "##.##", "#.#.#", "#.#.#", "#...#", "#...#", "#...#"},
        '{"#...#", "#...#", "##..#", "#.#.#", "#..##", "#...#", "#...#"},
        '{".###.", "#...#", "#...#", "#...#", "#...#", "#...#", ".###."},
        '{"####.", "#...#", "#...#", "####.", "#....", "#....", "#...."}
    };

    typedef struct {
        bit valid;
        int x;
        int y;
        int colour;
        bit done;
    } beat_t;

    int    n_checks = 0;
    int    n_errors = 0;
    int    psx = 0, psy = 0;
    int    m_code [2][16];
    bit    m_vis  [2][16];
    beat_t p1, p2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (beat x=%0d y=%0d)", tag, obs, exp, p2.x, p2.y);
        end
    endtask

    function automatic bit glyph_lit(int code, int gx, int gy);
        string row;
        if (gy < 1 || gy > 14 || gx < 1 || gx > 5) return 1'b0;
        row = font[code][(gy - 1) / 2];
        return row[gx - 1] == "#";
    endfunction

    function automatic beat_t model_beat();
        beat_t b;
        int code = 0, gx = 0, gy = 0;
        bit vis = 1'b0;
        b.valid = run;
        b.x     = psx;
        b.y     = psy;
        b.done  = run && psx == 159 && psy == 119;
        if (psx >= 80 && psx < 88 && psy >= 80 && psy < 96) begin
            code = int'(cur_code); vis = cur_vis; gx = psx - 80; gy = psy - 80;
        end else if (psx < 128 && psy < 16) begin
            code = m_code[0][psx / 8]; vis = m_vis[0][psx / 8]; gx = psx % 8; gy = psy;
        end else if (psx < 128 && psy >= 20 && psy < 36) begin
            code = m_code[1][psx / 8]; vis = m_vis[1][psx / 8]; gx = psx % 8; gy = psy - 20;
        end
        b.colour = (vis && glyph_lit(code, gx, gy)) ? int'(fg_colour) : 0;
        return b;
    endfunction

    // Advance the reference one clock with the inputs currently driven, then compare
    task automatic step();
        if (reset) begin
            p1 = '{default: 0};
            p2 = '{default: 0};
            psx = 0;
            psy = 0;
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 16; c++) begin
                    m_code[r][c] = 0;
                    m_vis[r][c]  = 1'b0;
                end
        end else begin
            p2 = p1;
            p1 = model_beat();
            if (wr_en) begin
                m_code[wr_row][wr_col] = int'(wr_code);
                m_vis[wr_row][wr_col]  = wr_vis;
            end
            if (run) begin
                if (psx == 159) begin
                    psx = 0;
                    psy = (psy == 119) ? 0 : psy + 1;
                end else begin
                    psx++;
                end
            end
        end
        @(posedge CLOCK_50);
        #1;
        check("plot", 32'(plot), 32'(p2.valid));
        check("frame_done", 32'(frame_done), 32'(p2.done));
        if (p2.valid) begin
            check("x", 32'(x), p2.x);
            check("y", 32'(y), p2.y);
            check("colour", 32'(colour), p2.colour);
        end
        if (reset) begin
            check("reset_x", 32'(x), 0);
            check("reset_y", 32'(y), 0);
            check("reset_colour", 32'(colour), 0);
        end
        @(negedge CLOCK_50);
    endtask

    task automatic write_cell(input bit row, input int col, input int code, input bit vis);
        wr_en = 1'b1; wr_row = row; wr_col = 4'(col); wr_code = 4'(code); wr_vis = vis;
        step();
        wr_en = 1'b0;
    endtask

    initial begin
        int  hold;
        bit  dropped, found;
        p1 = '{default: 0};
        p2 = '{default: 0};
        reset = 1'b1; run = 1'b0; fg_colour = 3'd0; wr_en = 1'b0; wr_row = 1'b0;
        wr_col = 4'd0; wr_code = 4'd0; wr_vis = 1'b0; cur_code = 4'd0; cur_vis = 1'b0;
        @(negedge CLOCK_50);
        repeat (3) step();
        reset = 1'b0;

        // Blank frame with a 10-cycle stall at (50,10)
        fg_colour = 3'($urandom_range(1, 7));
        hold = 0;
        dropped = 1'b0;
        for (int i = 0; i < 19212; i++) begin
            if (!dropped && psx == 50 && psy == 10) begin
                dropped = 1'b1;
                hold = 10;
            end
            run = (hold == 0);
            if (hold > 0) hold--;
            step();
        end
        run = 1'b1;

        fg_colour = 3'b010;
        write_cell(1'b0, 2, 12, 1'b1);
        write_cell(1'b1, 15, 0, 1'b1);
        cur_vis = 1'b1;
        cur_code = 4'd2;
        repeat (19200) step();

        // Random traffic: stalls, per-pixel colour, mid-frame writes, cursor changes
        for (int i = 0; i < 12000; i++) begin
            run = ($urandom_range(0, 9) != 0);
            fg_colour = 3'($urandom);
            cur_code = 4'($urandom);
            if (i % 500 == 0) cur_vis = 1'($urandom);
            wr_en = ($urandom_range(0, 39) == 0);
            wr_row = 1'($urandom);
            wr_col = 4'($urandom);
            wr_code = 4'($urandom);
            wr_vis = ($urandom_range(0, 3) != 0);
            step();
        end
        wr_en = 1'b0;
        run = 1'b1;

        found = 1'b0;
        for (int i = 0; i < 20000 && !found; i++) begin
            if (psx == 100 && psy == 60) found = 1'b1;
            else step();
        end
        check("reached_100_60", 32'(found), 1);

        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        cur_vis = 1'b0;
        fg_colour = 3'b111;
        repeat (6402) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
